apb_reg_slave: RTL and testbench
================================

// Module: apb_reg_slave
// PURPOSE
//  Register-bank target on the slave side of the apb bridge: consumes the bridge's o_valid/o_addr/
//  o_rd0_wr1/o_wr_data and returns ready, rd_valid and rd_data. Holds NUM_REGS word registers with
//  a programmable wait-state count to emulate slow peripherals. Reg 0 is a read-only ID register.
// PARAMETERS
//  addr_width   32            address bus width
//  data_width   32            data bus width
//  NUM_REGS     16            number of word registers (>=2); index = (addr-BASE_ADDR)>>2
//  BASE_ADDR    32'h0000_0000 byte address of reg 0; must be word aligned
//  WAIT_CYCLES  2             wait states before the response cycle (0..255)
//  ID_VALUE     32'hA5B0_0001 constant returned by reg 0
//  OOR_VALUE    32'hDEAD_0BAD read data for an out-of-range address
// PORTS
//  i_clk_apb   in   1           clock; all logic rising-edge
//  i_rst_apb   in   1           synchronous, active-high reset
//  i_valid     in   1           request present (bridge o_valid); held until o_ready
//  i_addr      in   addr_width  byte address (bridge o_addr); bits [1:0] ignored
//  i_rd0_wr1   in   1           0 = read, 1 = write (bridge o_rd0_wr1)
//  i_wr_data   in   data_width  write data (bridge o_wr_data)
//  o_ready     out  1           one-cycle completion strobe (to bridge i_ready)
//  o_rd_valid  out  1           read data valid, coincident with o_ready on reads
//  o_rd_data   out  data_width  read data; 0 when o_rd_valid = 0
// BEHAVIOUR
//  Reset: o_ready=0, o_rd_valid=0, o_rd_data=0, regs 1..NUM_REGS-1 = 0, wait counter = 0, FSM=IDLE.
//  FSM:
//   IDLE: o_ready=0. If i_valid: latch addr/rd0_wr1/wr_data, load cnt=WAIT_CYCLES;
//         go WAIT if WAIT_CYCLES>0, else RESP.
//   WAIT: cnt decrements each cycle; when cnt==1 go RESP. Inputs ignored (latched copy used).
//   RESP: o_ready=1 for exactly one cycle. Read: o_rd_valid=1, o_rd_data=selected value.
//         Write: register updated at the clock edge ending RESP. Next state always IDLE.
//  Latency: i_valid sampled in IDLE at edge N -> o_ready high in cycle N+WAIT_CYCLES+1.
//   Back-to-back with i_valid held: one transfer every WAIT_CYCLES+2 cycles (1 IDLE cycle between).
//  Decode: off = i_addr - BASE_ADDR (addr_width wrap arithmetic); in range iff off[addr_width-1:2]
//   < NUM_REGS. Addresses below BASE_ADDR wrap to a large offset -> out of range.
//  Reg 0: reads return ID_VALUE; writes complete normally (o_ready pulses) but are discarded.
//  Out of range: writes complete and are discarded; reads return OOR_VALUE.
//  Read-after-write to same reg returns the new value (write committed before next IDLE).
//  i_valid dropping mid-transfer does not abort; latched request completes.
//  Reset mid-transfer (WAIT or RESP): FSM to IDLE, outputs to 0, pending write not committed.
//  i_valid asserted in the same cycle as reset: ignored; must be re-sampled in IDLE after reset.
// TESTING
//  1 Reset: assert i_rst_apb 2 cycles -> o_ready/o_rd_valid/o_rd_data = 0; read BASE+4 returns 0.
//  2 Write 32'hDEADBEEF to BASE+4, WAIT_CYCLES=2 -> o_ready high exactly cycle 3 after accept,
//    o_rd_valid=0; read BASE+4 -> o_rd_valid with o_ready, o_rd_data=32'hDEADBEEF.
//  3 Write 32'h1234_5678 to BASE+0 -> o_ready pulses; read BASE+0 -> 32'hA5B0_0001.
//  4 Read BASE+32'h40 (index 16) and BASE-4 -> 32'hDEAD_0BAD; write to BASE+32'h40 leaves regs
//    1..15 unchanged; read BASE+32'h7 -> reg 1 (low bits ignored).
//  5 i_valid held high for 4 writes, WAIT_CYCLES=0 -> o_ready pulses every 2 cycles; WAIT_CYCLES=2 ->
//    every 4 cycles; all four values read back correctly.
//  6 Write 32'hCAFEBABE to BASE+8, assert reset during WAIT -> no o_ready; read BASE+8 returns 0.

Source files
------------

// File: rtl/apb_reg_slave.sv
// apb_reg_slave
// Register-bank target behind the APB bridge. Accepts one request at a time
// from the bridge, inserts a fixed number of wait states, then completes it
// with a single-cycle o_ready strobe. Reg 0 is a read-only ID word. Reads
// outside the bank return a marker value, and writes outside it are dropped.
//
// Handshake: the bridge raises i_valid and holds i_addr/i_rd0_wr1/i_wr_data
// until it sees o_ready. The slave samples the request only in IDLE and
// copies it into internal registers, so later input changes are ignored.
// o_ready is high for exactly one cycle (RESP). On reads, o_rd_valid and
// o_rd_data are valid in that same cycle. At all other times o_rd_data is 0.
// A write is committed on the clock edge that ends RESP. A transfer that
// immediately follows therefore sees the new value.
//
// o_dbg_state exposes the FSM state for external checkers:
// 0 = IDLE, 1 = WAIT, 2 = RESP.

module apb_reg_slave #(
  parameter int unsigned           addr_width  = 32,
  parameter int unsigned           data_width  = 32,
  parameter int unsigned           NUM_REGS    = 16,
  parameter logic [addr_width-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_CYCLES = 2,
  parameter logic [data_width-1:0] ID_VALUE    = 32'hA5B0_0001,
  parameter logic [data_width-1:0] OOR_VALUE   = 32'hDEAD_0BAD
) (
  input  logic                  i_clk_apb,
  input  logic                  i_rst_apb,
  input  logic                  i_valid,
  input  logic [addr_width-1:0] i_addr,
  input  logic                  i_rd0_wr1,
  input  logic [data_width-1:0] i_wr_data,
  output logic                  o_ready,
  output logic                  o_rd_valid,
  output logic [data_width-1:0] o_rd_data,
  output logic [1:0]            o_dbg_state
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0]  WAIT_LOAD = 8'(WAIT_CYCLES);
  localparam logic [addr_width-3:0] REG_LIMIT = (addr_width-2)'(NUM_REGS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;

  // Latched copy of the accepted request
  logic [addr_width-1:0] addr_q;
  logic                  wr_q;
  logic [data_width-1:0] wdata_q;

  // Storage. Entry 0 is never written; reg 0 reads come from ID_VALUE.
  logic [data_width-1:0] regs [NUM_REGS];

  // Address decode on the latched address
  logic [addr_width-1:0] off;
  logic [addr_width-3:0] word;
  logic                  in_range;
  logic [IDX_W-1:0]      idx;
  logic                  is_id;
  logic                  unused_low_bits;
  logic [data_width-1:0] rd_sel;
  logic                  commit_wr;

  // Subtraction wraps, so addresses below BASE_ADDR decode as huge offsets (out of range)
  assign off             = addr_q - BASE_ADDR;
  assign word            = off[addr_width-1:2];
  assign in_range        = (word < REG_LIMIT);
  assign idx             = word[IDX_W-1:0];
  assign is_id           = in_range && (idx == '0);
  assign unused_low_bits = &{1'b0, off[1:0]};

  // A write takes effect only at the end of RESP, and only for writable in-range regs
  assign commit_wr = (state == S_RESP) && wr_q && in_range && !is_id;

  // Read mux: ID word, bank register, or out-of-range marker
  always_comb begin
    rd_sel = OOR_VALUE;
    if (in_range) begin
      if (is_id) begin
        rd_sel = ID_VALUE;
      end else begin
        rd_sel = regs[idx];
      end
    end
  end

  // State register, wait counter and request capture
  always_ff @(posedge i_clk_apb) begin
    if (i_rst_apb) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == S_IDLE && i_valid) begin
        addr_q  <= i_addr;
        wr_q    <= i_rd0_wr1;
        wdata_q <= i_wr_data;
      end
    end
  end

  // Next-state logic: IDLE -> (WAIT x WAIT_CYCLES) -> RESP -> IDLE
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (i_valid) begin
          cnt_nxt   = WAIT_LOAD;
          state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 8'd1;
        if (cnt <= 8'd1) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Register bank: cleared by reset, which also drops any pending write
  always_ff @(posedge i_clk_apb) begin
    if (i_rst_apb) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else if (commit_wr) begin
      regs[idx] <= wdata_q;
    end
  end

  // Response outputs are decoded from the state so they are 0 outside RESP
  always_comb begin
    o_ready     = (state == S_RESP);
    o_rd_valid  = (state == S_RESP) && !wr_q;
    o_rd_data   = o_rd_valid ? rd_sel : '0;
    o_dbg_state = state;
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// tb_apb_reg_slave
// Two slaves share a clock and a reset. dut0 has WAIT_CYCLES=2 and BASE=0.
// dut1 has WAIT_CYCLES=0 and BASE=0x1000. A transaction-level model predicts
// the response cycle and the read data. A negedge compare process checks
// every DUT output on every cycle. Directed tasks pin latency and literal values.

module tb_apb_reg_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid [2];
  logic [31:0] addr  [2];
  logic        wr    [2];
  logic [31:0] wdata [2];
  logic        ready [2];
  logic        rdv   [2];
  logic [31:0] rdata [2];
  logic [1:0]  dbg0;
  logic [1:0]  dbg1;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  apb_reg_slave #(.WAIT_CYCLES(2), .BASE_ADDR(32'h0000_0000)) dut0 (
    .i_clk_apb(clk), .i_rst_apb(rst), .i_valid(valid[0]), .i_addr(addr[0]),
    .i_rd0_wr1(wr[0]), .i_wr_data(wdata[0]), .o_ready(ready[0]),
    .o_rd_valid(rdv[0]), .o_rd_data(rdata[0]), .o_dbg_state(dbg0));

  apb_reg_slave #(.WAIT_CYCLES(0), .BASE_ADDR(32'h0000_1000)) dut1 (
    .i_clk_apb(clk), .i_rst_apb(rst), .i_valid(valid[1]), .i_addr(addr[1]),
    .i_rd0_wr1(wr[1]), .i_wr_data(wdata[1]), .o_ready(ready[1]),
    .o_rd_valid(rdv[1]), .o_rd_data(rdata[1]), .o_dbg_state(dbg1));

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? 32'h0000_0000 : 32'h0000_1000;
  endfunction

  function automatic int wc_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // ---------------- behavioural model ----------------
  int          edge_n = 0;
  bit          m_pend  [2];
  int          m_end   [2];   // edge index that closes the response cycle
  bit          m_wr    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_regs  [2][16];
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  // Word index of an address, or -1 when it falls outside the 16-word bank
  function automatic int word_of(input int d, input logic [31:0] a);
    logic [31:0] w;
    w = (a - base_of(d)) >> 2;
    if (w >= 32'd16) return -1;
    return int'(w);
  endfunction

  function automatic logic [31:0] model_read(input int d, input logic [31:0] a);
    int k;
    k = word_of(d, a);
    if (k < 0) return 32'hDEAD_0BAD;
    if (k == 0) return 32'hA5B0_0001;
    return m_regs[d][k];
  endfunction

  // A request accepted at edge E responds in the cycle closed by edge E+W+1.
  // The next request can be accepted from edge E+W+2 on.
  always @(posedge clk) begin
    edge_n++;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_pend[d] = 1'b0;
        for (int k = 0; k < 16; k++) m_regs[d][k] = '0;
        if (d == 0) exp_q0.delete(); else exp_q1.delete();
      end else if (m_pend[d]) begin
        if (edge_n == m_end[d]) begin
          if (m_wr[d] && word_of(d, m_addr[d]) > 0)
            m_regs[d][word_of(d, m_addr[d])] = m_wdata[d];
          m_pend[d] = 1'b0;
        end
      end else if (valid[d]) begin
        m_pend[d]  = 1'b1;
        m_wr[d]    = wr[d];
        m_addr[d]  = addr[d];
        m_wdata[d] = wdata[d];
        m_end[d]   = edge_n + wc_of(d) + 1;
        if (!wr[d]) begin
          if (d == 0) exp_q0.push_back(model_read(d, addr[d]));
          else        exp_q1.push_back(model_read(d, addr[d]));
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t actual=%h expected=%h", name, d, $time, act, exp);
    end
  endtask

  bit          c_er;
  bit          c_ev;
  logic [31:0] c_ed;

  // Compare every output of both DUTs against the model on every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        c_er = m_pend[d] && (edge_n == m_end[d] - 1);
        c_ev = c_er && !m_wr[d];
        c_ed = '0;
        if (c_ev) begin
          if (d == 0 && exp_q0.size() > 0)      c_ed = exp_q0.pop_front();
          else if (d == 1 && exp_q1.size() > 0) c_ed = exp_q1.pop_front();
          else chk("exp_q_underflow", d, 32'd0, 32'd1);
        end
        chk("ready", d, {31'd0, ready[d]}, {31'd0, c_er});
        chk("rd_valid", d, {31'd0, rdv[d]}, {31'd0, c_ev});
        chk("rd_data", d, rdata[d], c_ed);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One transfer. With drop set, i_valid falls and the inputs are scrambled
  // right after acceptance.
  task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] dat,
                      input bit drop, output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    valid[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = dat;
    lat = -1;
    rd  = '0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (ready[d]) begin
        lat = n - 1;
        rd  = rdata[d];
        break;
      end
      if (n == 2 && drop) begin
        valid[d] = 1'b0; addr[d] = $urandom; wdata[d] = $urandom; wr[d] = 1'($urandom_range(0, 1));
      end
    end
    if (lat < 0) chk("xfer_timeout", d, 32'd0, 32'd1);
    @(posedge clk); #1;
    valid[d] = 1'b0;
  endtask

  task automatic wr_chk(input int d, input logic [31:0] a, input logic [31:0] dat);
    logic [31:0] rd;
    int lat;
    xfer(d, 1'b1, a, dat, 1'b0, rd, lat);
    chk("wr_latency", d, lat, wc_of(d) + 1);
    chk("wr_rd_data_zero", d, rd, 32'd0);
  endtask

  task automatic rd_chk(input int d, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    int lat;
    xfer(d, 1'b0, a, 32'd0, 1'b0, rd, lat);
    chk("rd_latency", d, lat, wc_of(d) + 1);
    chk("rd_value", d, rd, exp);
  endtask

  // Four writes with i_valid held high. Checks the spacing between o_ready pulses.
  task automatic burst(input int d);
    int c;
    int prev;
    bit seen;
    logic [31:0] vals [4];
    vals[0] = 32'h1111_0001; vals[1] = 32'h2222_0002; vals[2] = 32'h3333_0003; vals[3] = 32'h4444_0004;
    c = 0;
    prev = -1;
    @(posedge clk); #1;
    valid[d] = 1'b1; wr[d] = 1'b1; addr[d] = base_of(d) + 32'd4; wdata[d] = vals[0];
    for (int k = 0; k < 4; k++) begin
      seen = 1'b0;
      for (int n = 0; n < 50; n++) begin
        @(negedge clk);
        c++;
        if (ready[d]) begin seen = 1'b1; break; end
      end
      if (!seen) chk("burst_timeout", d, 32'd0, 32'd1);
      if (prev >= 0) chk("burst_spacing", d, c - prev, wc_of(d) + 2);
      prev = c;
      @(posedge clk); #1;
      if (k < 3) begin
        addr[d]  = base_of(d) + 32'(4 * (k + 2));
        wdata[d] = vals[k + 1];
      end else begin
        valid[d] = 1'b0;
      end
    end
    for (int k = 0; k < 4; k++) rd_chk(d, base_of(d) + 32'(4 * (k + 1)), vals[k]);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int seen;
    logic [31:0] rd;
    logic [31:0] a;
    int lat;
    int d;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      valid[i] = 1'b0; addr[i] = '0; wr[i] = 1'b0; wdata[i] = '0;
    end
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("reset_ready", i, {31'd0, ready[i]}, 32'd0);
      chk("reset_rd_valid", i, {31'd0, rdv[i]}, 32'd0);
      chk("reset_rd_data", i, rdata[i], 32'd0);
      rd_chk(i, base_of(i) + 32'd4, 32'd0);
    end

    // Basic write then read-back, and ID register behaviour
    for (int i = 0; i < 2; i++) begin
      wr_chk(i, base_of(i) + 32'd4, 32'hDEAD_BEEF);
      rd_chk(i, base_of(i) + 32'd4, 32'hDEAD_BEEF);
      wr_chk(i, base_of(i), 32'h1234_5678);
      rd_chk(i, base_of(i), 32'hA5B0_0001);
    end

    // Out of range, wrap below base, low address bits ignored
    for (int i = 0; i < 2; i++) begin
      rd_chk(i, base_of(i) + 32'h40, 32'hDEAD_0BAD);
      rd_chk(i, base_of(i) - 32'd4, 32'hDEAD_0BAD);
      wr_chk(i, base_of(i) + 32'h40, 32'hFFFF_FFFF);
      rd_chk(i, base_of(i) + 32'h3C, 32'd0);
      rd_chk(i, base_of(i) + 32'h7, 32'hDEAD_BEEF);
    end

    burst(1);
    burst(0);

    // Reset while the write to reg 2 is still in WAIT
    @(posedge clk); #1;
    valid[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h8; wdata[0] = 32'hCAFE_BABE;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    valid[0] = 1'b0;
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (ready[0]) seen++;
      if (n == 1) rst = 1'b0;
    end
    chk("reset_abort_no_ready", 0, seen, 0);
    rd_chk(0, 32'h8, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      d = int'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0, 1, 2: a = base_of(d) + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        3:       a = base_of(d) + 32'h40 + 32'(4 * $urandom_range(0, 7));
        4:       a = base_of(d) - 32'(4 * $urandom_range(1, 4));
        default: a = $urandom;
      endcase
      xfer(d, 1'($urandom_range(0, 1)), a, $urandom, ($urandom_range(0, 3) == 0), rd, lat);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (5) @(negedge clk);
    chk("exp_q0_drained", 0, exp_q0.size(), 0);
    chk("exp_q1_drained", 1, exp_q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
